// File: rtl/uart_receiver.sv
// Oversampled UART receiver: recovers LSB-first frames and reports each byte with a done strobe and error flags.
// Optional parity stage is compiled in when RX_PARITY_EN is defined.
module uart_receiver #(
  parameter int unsigned D_BITS     = 8,
  parameter int unsigned SP_BITS    = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  input  logic              i_s_tick,
  output logic [D_BITS-1:0] o_rx_data,
  output logic              o_rx_done,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic              o_busy
);

  localparam int unsigned TK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BC_W = (D_BITS > 1) ? $clog2(D_BITS) : 1;
  localparam int unsigned SB_W = (SP_BITS > 1) ? $clog2(SP_BITS) : 1;

  localparam logic [TK_W-1:0] TK_MID  = TK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TK_W-1:0] TK_END  = TK_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(D_BITS - 1);
  localparam logic [SB_W-1:0] SB_LAST = SB_W'(SP_BITS - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic [TK_W-1:0]   r_tk;
  logic [TK_W-1:0]   w_tk_next;
  logic [BC_W-1:0]   r_bc;
  logic [BC_W-1:0]   w_bc_next;
  logic [SB_W-1:0]   r_sb;
  logic [SB_W-1:0]   w_sb_next;
  logic [D_BITS-1:0] r_shift;
  logic [D_BITS-1:0] w_shift_next;
  logic              r_ferr_sticky;
  logic              w_ferr_next;
  logic [D_BITS-1:0] r_rx_data;
  logic [D_BITS-1:0] w_rx_data_next;
  logic              r_rx_done;
  logic              w_rx_done_next;
  logic              r_frame_err;
  logic              w_frame_err_next;
  logic              r_busy;
  logic              w_stop_low;

`ifdef RX_PARITY_EN
  logic              r_par_ok;
  logic              w_par_ok_next;
  logic              r_parity_err;
  logic              w_parity_err_next;
  logic              w_par_calc;

  // Odd sense folds in as an extra '1' so a correct frame always XORs to zero.
  assign w_par_calc = ^{r_shift, r_rx_s, 1'(PARITY_ODD)};
`else
  logic              w_unused_parity_odd;
  assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_tk          <= '0;
      r_bc          <= '0;
      r_sb          <= '0;
      r_shift       <= '0;
      r_ferr_sticky <= 1'b0;
      r_rx_data     <= '0;
      r_rx_done     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_ok      <= 1'b1;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_tk          <= w_tk_next;
      r_bc          <= w_bc_next;
      r_sb          <= w_sb_next;
      r_shift       <= w_shift_next;
      r_ferr_sticky <= w_ferr_next;
      r_rx_data     <= w_rx_data_next;
      r_rx_done     <= w_rx_done_next;
      r_frame_err   <= w_frame_err_next;
      r_busy        <= (w_state_next != ST_IDLE);
`ifdef RX_PARITY_EN
      r_par_ok      <= w_par_ok_next;
      r_parity_err  <= w_parity_err_next;
`endif
    end
  end

  assign w_stop_low = ~r_rx_s;

  always_comb begin
    w_state_next     = r_state;
    w_tk_next        = r_tk;
    w_bc_next        = r_bc;
    w_sb_next        = r_sb;
    w_shift_next     = r_shift;
    w_ferr_next      = r_ferr_sticky;
    w_rx_data_next   = r_rx_data;
    w_rx_done_next   = 1'b0;
    w_frame_err_next = r_frame_err;
`ifdef RX_PARITY_EN
    w_par_ok_next     = r_par_ok;
    w_parity_err_next = r_parity_err;
`endif

    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = ST_START;
          w_tk_next    = '0;
        end
      end

      // Validate the start bit at its midpoint; a high line here was a glitch.
      ST_START: begin
        if (i_s_tick) begin
          if (r_tk == TK_MID) begin
            w_tk_next = '0;
            if (!r_rx_s) begin
              w_state_next = ST_DATA;
              w_bc_next    = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_tk_next = r_tk + TK_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (i_s_tick) begin
          if (r_tk == TK_END) begin
            w_tk_next    = '0;
            w_shift_next = {r_rx_s, r_shift[D_BITS-1:1]};
            if (r_bc == BC_LAST) begin
`ifdef RX_PARITY_EN
              w_state_next = ST_PARITY;
`else
              w_state_next = ST_STOP;
`endif
              w_sb_next   = '0;
              w_ferr_next = 1'b0;
            end else begin
              w_bc_next = r_bc + BC_W'(1);
            end
          end else begin
            w_tk_next = r_tk + TK_W'(1);
          end
        end
      end

`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (i_s_tick) begin
          if (r_tk == TK_END) begin
            w_tk_next     = '0;
            w_par_ok_next = ~w_par_calc;
            w_state_next  = ST_STOP;
            w_sb_next     = '0;
            w_ferr_next   = 1'b0;
          end else begin
            w_tk_next = r_tk + TK_W'(1);
          end
        end
      end
`endif

      // Frame ends at the middle of the last stop bit so back-to-back frames fit.
      ST_STOP: begin
        if (i_s_tick) begin
          if (r_tk == TK_END) begin
            w_tk_next   = '0;
            w_ferr_next = r_ferr_sticky | w_stop_low;
            if (r_sb == SB_LAST) begin
              w_rx_data_next   = r_shift;
              w_frame_err_next = r_ferr_sticky | w_stop_low;
              w_rx_done_next   = 1'b1;
              w_state_next     = ST_IDLE;
`ifdef RX_PARITY_EN
              w_parity_err_next = ~r_par_ok;
`endif
            end else begin
              w_sb_next = r_sb + SB_W'(1);
            end
          end else begin
            w_tk_next = r_tk + TK_W'(1);
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_tk_next    = '0;
      end
    endcase
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_done   = r_rx_done;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;
`ifdef RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one SP_BITS=1 instance and one SP_BITS=2 instance on separate lines.
module tb_uart_receiver;

  localparam int BIT = 64;  // clocks per bit: 16 ticks x 4 clocks
`ifdef RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       sel2 = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic       s_tick;
  logic       rx1, rx2;

  logic [7:0] data1, data2;
  logic       done1, done2, ferr1, ferr2, perr1, perr2, busy1, busy2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  int done_cyc2 = 0;
  int done_cyc2_prev = 0;
  logic [7:0] data2_last = 8'h00;
  logic [7:0] data2_prev = 8'h00;
  logic done_prev1 = 1'b0;
  logic busy_after1 = 1'bx;
  int base1, base2;

`ifdef RX_PARITY_EN
  logic par_force = 1'b0;
  logic par_val = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  always @(posedge clk) cyc <= cyc + 1;
  assign s_tick = (tcnt == 2'd3);
  assign rx1 = sel2 ? 1'b1 : rx_line;
  assign rx2 = sel2 ? rx_line : 1'b1;

  uart_receiver #(.D_BITS(8), .SP_BITS(1), .OVERSAMPLE(16), .PARITY_ODD(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .i_s_tick(s_tick),
    .o_rx_data(data1), .o_rx_done(done1), .o_frame_err(ferr1),
    .o_parity_err(perr1), .o_busy(busy1)
  );

  uart_receiver #(.D_BITS(8), .SP_BITS(2), .OVERSAMPLE(16), .PARITY_ODD(0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx2), .i_s_tick(s_tick),
    .o_rx_data(data2), .o_rx_done(done2), .o_frame_err(ferr2),
    .o_parity_err(perr2), .o_busy(busy2)
  );

  // Done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done_prev1) busy_after1 = busy1;
    done_prev1 = done1;
    if (done1) done_cnt1 = done_cnt1 + 1;
    if (done2) begin
      done_cnt2      = done_cnt2 + 1;
      done_cyc2_prev = done_cyc2;
      done_cyc2      = cyc;
      data2_prev     = data2_last;
      data2_last     = data2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int n_stop);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
`ifdef RX_PARITY_EN
    drive(par_force ? par_val : ^d, BIT);
`endif
    if (stop_ok) drive(1'b1, BIT * n_stop);
    else begin
      drive(1'b0, 48);
      drive(1'b1, 16);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data1), 32'h00);
    chk("rst_done", 32'(done1), 32'h0);
    chk("rst_ferr", 32'(ferr1), 32'h0);
    chk("rst_perr", 32'(perr1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // 1: clean 0xA5
    base1 = done_cnt1;
    busy_after1 = 1'bx;
    send_frame(8'hA5, 1'b1, 1);
    chk("t1_done_cnt", 32'(done_cnt1 - base1), 32'd1);
    chk("t1_data", 32'(data1), 32'hA5);
    chk("t1_ferr", 32'(ferr1), 32'h0);
    chk("t1_perr", 32'(perr1), 32'h0);
    chk("t1_busy_after_done", 32'(busy_after1), 32'h0);

    // 2: 4-tick low glitch
    base1 = done_cnt1;
    drive(1'b0, 8);
    chk("t2_busy_in_glitch", 32'(busy1), 32'h1);
    drive(1'b0, 8);
    drive(1'b1, BIT);
    chk("t2_busy_cleared", 32'(busy1), 32'h0);
    chk("t2_no_done", 32'(done_cnt1 - base1), 32'd0);
    chk("t2_data_held", 32'(data1), 32'hA5);

    // 3: bad stop bit, then a clean frame clears the flag
    base1 = done_cnt1;
    send_frame(8'h3C, 1'b0, 1);
    drive(1'b1, BIT);
    chk("t3_done_cnt", 32'(done_cnt1 - base1), 32'd1);
    chk("t3_data", 32'(data1), 32'h3C);
    chk("t3_ferr", 32'(ferr1), 32'h1);
    send_frame(8'h55, 1'b1, 1);
    chk("t3_data2", 32'(data1), 32'h55);
    chk("t3_ferr_clr", 32'(ferr1), 32'h0);

    // 4: back-to-back frames on the two-stop-bit instance
    sel2 = 1'b1;
    base2 = done_cnt2;
    send_frame(8'h00, 1'b1, 2);
    send_frame(8'hFF, 1'b1, 2);
    drive(1'b1, BIT);
    sel2 = 1'b0;
    chk("t4_done_cnt", 32'(done_cnt2 - base2), 32'd2);
    chk("t4_spacing", 32'(done_cyc2 - done_cyc2_prev), 32'(BIT * (11 + PBITS)));
    chk("t4_data0", 32'(data2_prev), 32'h00);
    chk("t4_data1", 32'(data2_last), 32'hFF);
    chk("t4_ferr", 32'(ferr2), 32'h0);

    // 5: reset during bit 4 of 0x81
    base1 = done_cnt1;
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT * 3);
    drive(1'b0, 32);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", 32'(data1), 32'h00);
    chk("t5_rst_done", 32'(done1), 32'h0);
    chk("t5_rst_ferr", 32'(ferr1), 32'h0);
    chk("t5_rst_perr", 32'(perr1), 32'h0);
    chk("t5_rst_busy", 32'(busy1), 32'h0);
    drive(1'b1, 20);
    rst_n = 1'b1;
    drive(1'b1, BIT * 2);
    chk("t5_no_stray", 32'(done_cnt1 - base1), 32'd0);
    send_frame(8'h7E, 1'b1, 1);
    chk("t5_done_cnt", 32'(done_cnt1 - base1), 32'd1);
    chk("t5_data", 32'(data1), 32'h7E);

`ifdef RX_PARITY_EN
    // 6: even parity, correct then wrong parity bit
    par_force = 1'b1;
    par_val = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    chk("t6_perr_ok", 32'(perr1), 32'h0);
    chk("t6_data_ok", 32'(data1), 32'h07);
    par_val = 1'b0;
    send_frame(8'h07, 1'b1, 1);
    chk("t6_perr_bad", 32'(perr1), 32'h1);
    chk("t6_data_bad", 32'(data1), 32'h07);
    par_force = 1'b0;
`else
    chk("t6_perr_tied", 32'(perr1), 32'h0);
`endif

    drive(1'b1, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive side paired with the existing 8N1-style transmitter. Same baud-tick scheme, but the tick runs at OVERSAMPLE× the baud rate.
- Recovers LSB-first frames from the serial line and presents each byte with a one-cycle done strobe and error flags.
- Sits between the board RX pin and the packet/command logic.

Parameters:
D_BITS, 8, data bits per frame
SP_BITS, 1, stop bits per frame (1 or 2)
OVERSAMPLE, 16, i_s_tick pulses per bit period (even, >=4)
PARITY_ODD, 0, parity sense when RX_PARITY_EN is defined (0 = even, 1 = odd)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  raw serial line, idle high, asynchronous to i_clk
i_s_tick  input  1  oversample tick, one-cycle pulse, OVERSAMPLE per bit
o_rx_data  output  D_BITS  last received byte, held until next done
o_rx_done  output  1  one-cycle pulse, frame complete, o_rx_data valid
o_frame_err  output  1  stop bit sampled low on frame reported by o_rx_done
o_parity_err  output  1  parity mismatch on frame reported by o_rx_done
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: async on i_rst_n low.
  - state=IDLE, counters=0, o_rx_data=0, o_rx_done=0, o_frame_err=0, o_parity_err=0, o_busy=0.
  - Both synchronizer flops reset to 1.
- i_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only; there is 2 clk of input latency.
- Tick counter tk counts i_s_tick pulses and advances only when i_s_tick=1.
- States: IDLE, START, DATA, PARITY (present only with macro), STOP.
- IDLE:
  - On rx_s==0: go to START, tk=0.
  - No tick is required to leave IDLE.
- START:
  - On the tick where tk==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0: go to DATA, tk=0, bit count bc=0.
    - rx_s==1: glitch. Return to IDLE silently; no done, no error.
- DATA:
  - On the tick where tk==OVERSAMPLE-1 (mid bit): shift rx_s into the MSB of the shift register (right shift), tk=0.
  - bc==D_BITS-1: go to PARITY if present, else STOP, with sb=0. Otherwise bc+1.
- PARITY:
  - At mid bit, capture par_ok = (XOR of the D_BITS data bits XOR rx_s XOR PARITY_ODD) == 0.
  - Then go to STOP, tk=0.
- STOP:
  - At each mid bit, OR (rx_s==0) into a sticky frame-error flag.
  - When sb==SP_BITS-1, on the same clk edge:
    - o_rx_data <= shift register.
    - o_frame_err <= sticky flag.
    - o_parity_err <= !par_ok.
    - o_rx_done <= 1 for one cycle.
    - Go to IDLE.
  - Otherwise sb+1, tk=0.
- Latency: o_rx_done rises on the clk edge after the i_s_tick that samples the mid point of the last stop bit. A frame ends half a bit early, so back-to-back frames are accepted with no gap.
- Framing error:
  - Byte is still delivered and done still pulses.
  - If rx_s is still low on return to IDLE, it is treated as a new start edge and revalidated in START (break condition yields repeated 0x00 + frame_err).
- o_frame_err and o_parity_err hold their value until the next done. They update only at done.
- o_rx_data is never changed except at done.
- Simultaneous i_s_tick with a state entry: a tick in the cycle of IDLE->START does not count. tk starts at 0 on the first tick after entry.
- Reset mid-frame: abort immediately, all outputs return to reset values, and the partial byte is discarded.
- Widths:
  - tk is $clog2(OVERSAMPLE) bits and wraps only by explicit clear.
  - bc is $clog2(D_BITS) bits; sb is max(1,$clog2(SP_BITS)) bits (no zero-width vectors).
- Unreachable state encodings return to IDLE.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - PARITY state is inserted; frame = start + D_BITS + parity + SP_BITS.
  - o_parity_err reports the mismatch as described above.
- Undefined:
  - PARITY state, par_ok logic and parity counter are not compiled.
  - o_parity_err is tied 0 and the port remains present.
  - Frame = start + D_BITS + SP_BITS.

Test Plan:
1. Reset released, OVERSAMPLE=16, send 0xA5 8N1 (line bits 0,1,0,1,0,0,1,0,1,1) -> exactly one o_rx_done pulse, o_rx_data=0xA5, o_frame_err=0, o_busy low one clk after done.
2. Low glitch of 4 tick periods on idle line -> o_busy high then back to 0 at tick 8, no o_rx_done, o_rx_data unchanged.
3. Send 0x3C with stop bit driven 0 -> done pulses, o_rx_data=0x3C, o_frame_err=1. Then a valid 0x55 -> o_frame_err=0.
4. Back-to-back 0x00 then 0xFF with no idle gap, SP_BITS=2 -> two done pulses exactly 11 bit periods apart, data 0x00 then 0xFF.
5. Assert i_rst_n low during bit 4 of 0x81, release, send 0x7E -> all outputs 0 during reset, next done carries 0x7E with no stray done from the aborted frame.
6. RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 1 -> o_parity_err=0. Send 0x07 with parity bit 0 -> o_parity_err=1, o_rx_data=0x07.
